// File: rtl/booth_seq_ctrl.sv
// Control sequencer for a radix-2 Booth multiplier: LOAD, then N_BITS EVAL/SHIFT pairs, then DONE.
// Optional abort input enabled by defining BOOTH_SEQ_CTRL_ABORT_EN.
module booth_seq_ctrl #(
  parameter int N_BITS = 4,
  parameter int CNT_W  = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
`ifdef BOOTH_SEQ_CTRL_ABORT_EN
  input  logic       abort,
`endif
  input  logic [1:0] q_pair,
  output logic [1:0] q_ctrl,
  output logic [2:0] a_ctrl,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EVAL  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BITS - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             w_active;
  logic             w_abort;
  logic             w_last;

  assign w_active = (r_state == S_LOAD) || (r_state == S_EVAL) || (r_state == S_SHIFT);
  assign w_last   = (r_count == LAST_CNT);

`ifdef BOOTH_SEQ_CTRL_ABORT_EN
  assign w_abort = abort && w_active;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else if (w_abort) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_count <= '0;
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_count <= r_count + 1'b1;
            r_state <= S_EVAL;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  // Codes are decoded from the registered state; the EVAL op also looks at q_pair,
  // which the datapath holds steady through that cycle.
  always_comb begin
    q_ctrl = 2'b11;
    a_ctrl = 3'b000;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_LOAD: begin
        q_ctrl = 2'b00;
        a_ctrl = 3'b001;
        busy   = 1'b1;
      end
      S_EVAL: begin
        busy = 1'b1;
        case (q_pair)
          2'b01:   a_ctrl = 3'b010;
          2'b10:   a_ctrl = 3'b011;
          default: a_ctrl = 3'b000;
        endcase
      end
      S_SHIFT: begin
        q_ctrl = 2'b10;
        a_ctrl = 3'b100;
        busy   = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
    // Nothing may reach the datapath while reset is held or on the cycle an abort lands.
    if (reset || w_abort) begin
      q_ctrl = 2'b11;
      a_ctrl = 3'b000;
    end
    if (reset) begin
      busy = 1'b0;
      done = 1'b0;
    end
  end

endmodule
